// File: rtl/execute_muldiv_if.sv
// Purpose: EX-stage handshake bundle between the pipeline and the M-extension
//          multiply/divide unit.
// Signals: startE/mdCtrlE/srcAE/srcBE/flushE driven by the pipeline (master);
//          busyE/doneE/resultE driven by the unit (slave).
interface execute_muldiv_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  startE;
    logic [2:0]            mdCtrlE;
    logic [DATA_WIDTH-1:0] srcAE;
    logic [DATA_WIDTH-1:0] srcBE;
    logic                  flushE;
    logic                  busyE;
    logic                  doneE;
    logic [DATA_WIDTH-1:0] resultE;

    modport master (
        output startE, mdCtrlE, srcAE, srcBE, flushE,
        input  busyE, doneE, resultE
    );

    modport slave (
        input  startE, mdCtrlE, srcAE, srcBE, flushE,
        output busyE, doneE, resultE
    );
endinterface

// File: rtl/execute_muldiv.sv
// Purpose: iterative RV32M multiply/divide unit for the EX stage. One bit per
//          cycle: shift-add multiply, restoring divide, on operand magnitudes
//          with a final sign correction.
// Ports:   clk     - clock, rising edge
//          rst_n   - asynchronous active-low reset
//          md      - slave side of execute_muldiv_if (start/op/operands/flush
//                    in; busy stall request, one-cycle done pulse, result out)
module execute_muldiv #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    execute_muldiv_if.slave  md
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    mag_a_q, mag_a_d;
    logic [W-1:0]    mag_b_q, mag_b_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [W-1:0]    result_q, result_d;
    logic            done_q, done_d;

    // Operand decode for the instruction currently offered in EX
    logic            in_a_sgn, in_b_sgn, in_a_neg, in_b_neg;
    logic [W-1:0]    in_mag_a, in_mag_b;
    logic            in_div0, in_ovf;
    logic [W-1:0]    in_spec_res;

    assign in_a_sgn = (md.mdCtrlE != 3'b011) && (md.mdCtrlE != 3'b101) && (md.mdCtrlE != 3'b111);
    assign in_b_sgn = (md.mdCtrlE == 3'b000) || (md.mdCtrlE == 3'b001) ||
                      (md.mdCtrlE == 3'b100) || (md.mdCtrlE == 3'b110);
    assign in_a_neg = in_a_sgn && md.srcAE[W-1];
    assign in_b_neg = in_b_sgn && md.srcBE[W-1];
    assign in_mag_a = in_a_neg ? W'(0) - md.srcAE : md.srcAE;
    assign in_mag_b = in_b_neg ? W'(0) - md.srcBE : md.srcBE;
    assign in_div0  = md.mdCtrlE[2] && (md.srcBE == '0);
    assign in_ovf   = md.mdCtrlE[2] && !md.mdCtrlE[0] &&
                      (md.srcAE == {1'b1, {(W-1){1'b0}}}) && (md.srcBE == '1);
    // REM-type ops have funct3[1] set
    assign in_spec_res = in_div0 ? (md.mdCtrlE[1] ? md.srcAE : '1)
                                 : (md.mdCtrlE[1] ? '0 : {1'b1, {(W-1){1'b0}}});

    // One multiply step: conditionally add multiplicand to the upper half, shift right
    logic [W:0]      mul_sum;
    logic [PW-1:0]   mul_next;
    assign mul_sum  = {1'b0, prod_q[PW-1:W]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
    assign mul_next = {mul_sum, prod_q[W-1:1]};

    // One divide step: upper half is partial remainder, lower half shifts dividend out / quotient in
    logic [W:0]      div_shl;
    logic            div_ge;
    logic [W-1:0]    div_diff, div_rem;
    logic [PW-1:0]   div_next;
    assign div_shl  = {prod_q[PW-1:W], prod_q[W-1]};
    assign div_ge   = div_shl >= {1'b0, mag_b_q};
    assign div_diff = div_shl[W-1:0] - mag_b_q;
    assign div_rem  = div_ge ? div_diff : div_shl[W-1:0];
    assign div_next = {div_rem, prod_q[W-2:0], div_ge};

    // Sign-corrected result of the last step
    logic [PW-1:0]   mul_fin;
    logic [W-1:0]    quot_fin, rem_fin, calc_res;
    assign mul_fin  = neg_q ? PW'(0) - mul_next : mul_next;
    assign quot_fin = neg_q ? W'(0) - div_next[W-1:0] : div_next[W-1:0];
    assign rem_fin  = neg_rem_q ? W'(0) - div_next[PW-1:W] : div_next[PW-1:W];

    always_comb begin
        case (op_q)
            3'b000:                 calc_res = mul_fin[W-1:0];
            3'b001, 3'b010, 3'b011: calc_res = mul_fin[PW-1:W];
            3'b100, 3'b101:         calc_res = quot_fin;
            default:                calc_res = rem_fin;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        prod_d    = prod_q;
        result_d  = result_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (md.startE && !md.flushE) begin
                    op_d      = md.mdCtrlE;
                    mag_a_d   = in_mag_a;
                    mag_b_d   = in_mag_b;
                    neg_d     = in_a_neg ^ in_b_neg;
                    neg_rem_d = in_a_neg;
                    if (in_div0 || in_ovf) begin
                        result_d = in_spec_res;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        prod_d  = md.mdCtrlE[2] ? {W'(0), in_mag_a} : {W'(0), in_mag_b};
                        cnt_d   = CW'(W - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (md.flushE) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        result_d = calc_res;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            prod_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            prod_q    <= prod_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    // Stall the pipeline from the offer cycle until the result is ready
    assign md.busyE   = rst_n && (((state_q == S_IDLE) && md.startE && !md.flushE) ||
                                  (state_q == S_CALC));
    assign md.doneE   = done_q;
    assign md.resultE = result_q;
endmodule

// File: tb/tb_execute_muldiv.sv
module tb_execute_muldiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_muldiv_if #(.DATA_WIDTH(32)) md();
    execute_muldiv #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .md(md));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural RV32M result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 32'd0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Issue one op and check busy/done every cycle until the done pulse has passed
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit hold);
        int lat;
        lat = is_special(op, a, b) ? 1 : 33;
        @(negedge clk);
        md.startE  = 1'b1;
        md.mdCtrlE = op;
        md.srcAE   = a;
        md.srcBE   = b;
        md.flushE  = 1'b0;
        #1;
        check({name, " busy@offer"}, 32'(md.busyE), 32'd1);
        check({name, " done@offer"}, 32'(md.doneE), 32'd0);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            if (k == 1 && !hold) begin
                #1;
                md.startE  = 1'b0;
                md.mdCtrlE = 3'($urandom);
                md.srcAE   = $urandom;
                md.srcBE   = $urandom;
            end
            @(negedge clk);
            if (k < lat) begin
                check($sformatf("%s busy@E%0d", name, k - 1), 32'(md.busyE), 32'd1);
                check($sformatf("%s done@E%0d", name, k - 1), 32'(md.doneE), 32'd0);
            end else begin
                check({name, " done"}, 32'(md.doneE), 32'd1);
                check({name, " busy@done"}, 32'(md.busyE), 32'd0);
                check({name, " result"}, md.resultE, exp);
            end
        end
        @(posedge clk);
        #1;
        md.startE = 1'b0;
        @(negedge clk);
        check({name, " done after"}, 32'(md.doneE), 32'd0);
        check({name, " result held"}, md.resultE, exp);
        @(negedge clk);
        check({name, " no restart"}, 32'(md.doneE), 32'd0);
    endtask

    initial begin
        logic [31:0] pick [5];
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        pick[0] = 32'd0; pick[1] = 32'h80000000; pick[2] = 32'hFFFFFFFF;
        pick[3] = 32'd1; pick[4] = 32'd7;
        md.startE = 1'b0; md.mdCtrlE = '0; md.srcAE = '0; md.srcBE = '0; md.flushE = 1'b0;

        // Reset state, with startE asserted to show busy is masked
        #2 md.startE = 1'b1;
        #1;
        check("reset busy", 32'(md.busyE), 32'd0);
        check("reset done", 32'(md.doneE), 32'd0);
        check("reset result", md.resultE, 32'd0);
        @(negedge clk);
        md.startE = 1'b0;
        rst_n = 1'b1;

        // Hand-computed expectations
        do_op("MUL 7x-3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        do_op("MULH min^2",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        do_op("MULHU max^2",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        do_op("MULHSU -1xmax",3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        do_op("DIV -7/2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        do_op("REM -7/2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
        do_op("DIVU 100/7",   3'd5, 32'd100,      32'd7,        32'd14,       1'b0);
        do_op("REMU 100/7",   3'd7, 32'd100,      32'd7,        32'd2,        1'b0);
        do_op("DIVU 5/0",     3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0);
        do_op("REM 5/0",      3'd6, 32'd5,        32'd0,        32'd5,        1'b0);
        do_op("DIV ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        do_op("REM ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0);
        do_op("MUL hold",     3'd0, 32'd6,        32'd9,        32'd54,       1'b1);

        // Flush at E10
        @(negedge clk);
        md.startE = 1'b1; md.mdCtrlE = 3'd0; md.srcAE = 32'd5; md.srcBE = 32'd6;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1 md.startE = 1'b0;
        end
        @(negedge clk);
        check("flush busy@E10", 32'(md.busyE), 32'd1);
        md.flushE = 1'b1;
        @(posedge clk);
        #1 md.flushE = 1'b0;
        @(negedge clk);
        check("flush busy after", 32'(md.busyE), 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("flush no done", 32'(md.doneE), 32'd0);
        end
        do_op("MUL 3x4", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

        // Reset at E15
        @(negedge clk);
        md.startE = 1'b1; md.mdCtrlE = 3'd5; md.srcAE = 32'd1000; md.srcBE = 32'd3;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1 md.startE = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        md.startE = 1'b1;
        #1;
        check("rst done", 32'(md.doneE), 32'd0);
        check("rst result", md.resultE, 32'd0);
        check("rst busy", 32'(md.busyE), 32'd0);
        @(negedge clk);
        md.startE = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("post-rst no done", 32'(md.doneE), 32'd0);
        end
        do_op("DIVU after rst", 3'd5, 32'd1000, 32'd3, 32'd333, 1'b0);

        // Randomized ops against the model
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 32'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
            do_op($sformatf("rnd%0d op%0d %h,%h", n, rop, ra, rb), rop, ra, rb,
                  ref_result(rop, ra, rb), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width; only 32 is supported.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port startE, input, 1 bit: the EX-stage instruction is an M-extension op.
REQ-005 The module SHALL have port mdCtrlE, input, 3 bits: funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 The module SHALL have port srcAE, input, DATA_WIDTH: rs1 operand (multiplicand/dividend).
REQ-007 The module SHALL have port srcBE, input, DATA_WIDTH: rs2 operand (multiplier/divisor).
REQ-008 The module SHALL have port flushE, input, 1 bit: kill the EX-stage instruction.
REQ-009 The module SHALL have port busyE, output, 1 bit: stall request to the hazard unit.
REQ-010 The module SHALL have port doneE, output, 1 bit: resultE is valid this cycle.
REQ-011 The module SHALL have port resultE, output, DATA_WIDTH: the operation result.

Function
REQ-012 The module SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 IDLE with startE=1 and flushE=0 SHALL accept the op at the next edge E0: latch mdCtrlE, srcAE and srcBE, and store the operand magnitudes and result sign. Operands are signed per funct3; MULHSU treats A as signed and B as unsigned.
REQ-014 At E0 a divide op with srcBE=0 SHALL go directly to DONE with quotient 0xFFFFFFFF and remainder equal to srcAE.
REQ-015 At E0 a signed DIV/REM with srcAE=0x80000000 and srcBE=0xFFFFFFFF SHALL go directly to DONE with quotient 0x80000000 and remainder 0.
REQ-016 At E0 all other ops SHALL enter CALC with the bit counter set to 31.
REQ-017 CALC SHALL process one bit per edge: shift-add on a 64-bit product for multiply, restoring subtract-shift for divide.
REQ-018 In CALC the counter SHALL decrement each edge; the edge at which the counter equals 0 SHALL apply the final sign correction and enter DONE.
REQ-019 Normal latency SHALL be 32 CALC edges (E1..E32), with doneE high in the cycle after E32.
REQ-020 The special cases in REQ-014 and REQ-015 SHALL have doneE high in the cycle after E0.
REQ-021 Result selection SHALL be: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32]; DIV and DIVU give the quotient; REM and REMU give the remainder.
REQ-022 The remainder sign SHALL follow the dividend, and the quotient SHALL be negated when the operand signs differ (signed ops only).
REQ-023 doneE SHALL be high only in DONE, for exactly one cycle; DONE SHALL return to IDLE at the next edge.
REQ-024 busyE SHALL be (IDLE and startE and not flushE) or CALC, and 0 in DONE, so the pipeline advances while doneE=1.
REQ-025 In DONE, startE SHALL be ignored; the same instruction is still present and SHALL NOT be restarted.
REQ-026 flushE=1 in CALC or DONE SHALL return the FSM to IDLE at the next edge, with no later doneE for the killed op.
REQ-027 Changes to srcAE, srcBE or mdCtrlE after E0 SHALL NOT affect the result.
REQ-028 resultE SHALL update only on entry to DONE and SHALL hold its last value otherwise.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, counter 0, doneE=0, resultE=0, all operand/product/remainder registers 0.
REQ-030 While rst_n=0, busyE SHALL be 0.
REQ-031 Reset asserted during CALC SHALL abort the op, and no doneE SHALL follow reset release.
REQ-032 The first op after release SHALL be accepted normally.

Verification
REQ-033 The bench SHALL check: MUL 7 x -3 -> doneE in the cycle after E32, resultE 0xFFFFFFEB; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 The bench SHALL check: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 The bench SHALL check: DIVU 5/0 -> doneE one cycle after E0, resultE 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000.
REQ-036 The bench SHALL check: busyE is 1 from the start cycle through E32, 0 during DONE; startE held high during DONE causes no restart and exactly one doneE pulse.
REQ-037 The bench SHALL check: flushE pulsed at E10 -> IDLE after the next edge, doneE stays 0, and a following MUL 3 x 4 -> 12.
REQ-038 The bench SHALL check: rst_n low at E15 -> doneE=0 and resultE=0 immediately, and no doneE after release until a new startE.
